// File: rtl/issue_div_fifo_pkg.sv
// Shared types and sizing for the issue-to-divider queue: the issue/execute
// payload handed to the divide unit and the default queue depth.
package issue_div_fifo_pkg;

  localparam int DIV_FIFO_DEPTH = 16;
  localparam int ROB_ID_W       = 7;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_t;

  // fb_en is the downstream feedback enable; an all-zero pack leaves it low.
  typedef struct packed {
    logic                fb_en;
    div_op_t             op;
    logic [4:0]          rd_addr;
    logic [ROB_ID_W-1:0] rob_id;
    logic [31:0]         rs1_data;
    logic [31:0]         rs2_data;
  } issue_execute_pack_t;

  localparam int PACK_W = $bits(issue_execute_pack_t);

endpackage

// File: rtl/issue_div_fifo_core.sv
// Generic synchronous FIFO: wrap-bit pointers, registered-only flags, zero-latency
// head read through an asynchronous mux, flush clearing both pointers.
module sync_fifo_core #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int PTR_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [PTR_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic             push_ok;
  logic             pop_ok;

  // Flags depend on the pointer registers only, never on push/pop.
  assign empty = (rptr == wptr);
  assign full  = (rptr[AW] != wptr[AW]) && (rptr[AW-1:0] == wptr[AW-1:0]);
  assign count = wptr - rptr;

  // Flush outranks both ports; a push while full is dropped even if a pop frees a slot.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rptr <= '0;
      wptr <= '0;
    end else begin
      // NOTE: non-blocking updates so both pointers see pre-edge values of each other.
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; empty gating hides stale words.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= data_in;
  end

  assign data_out = mem[rptr[AW-1:0]];

endmodule

// File: rtl/issue_div_fifo.sv
// Issue-to-divider FIFO: wraps sync_fifo_core on the packed issue/execute payload
// and forces the head to all zeros while the queue is empty.
module issue_div_fifo
  import issue_div_fifo_pkg::*;
#(
  parameter  int DEPTH = DIV_FIFO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  issue_execute_pack_t issue_div_fifo_data_in,
  input  logic                issue_div_fifo_push,
  output logic                issue_div_fifo_full,
  output issue_execute_pack_t issue_div_fifo_data_out,
  output logic                issue_div_fifo_data_out_valid,
  input  logic                issue_div_fifo_pop,
  input  logic                issue_div_fifo_flush,
  output logic [CNT_W-1:0]    issue_div_fifo_count
);

  logic [PACK_W-1:0] head_bits;
  logic              empty;

  sync_fifo_core #(
    .WIDTH (PACK_W),
    .DEPTH (DEPTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .data_in  (issue_div_fifo_data_in),
    .push     (issue_div_fifo_push),
    .pop      (issue_div_fifo_pop),
    .flush    (issue_div_fifo_flush),
    .data_out (head_bits),
    .empty    (empty),
    .full     (issue_div_fifo_full),
    .count    (issue_div_fifo_count)
  );

  assign issue_div_fifo_data_out_valid = !empty;

  // A zero head keeps the divider's feedback enable low when nothing is queued.
  assign issue_div_fifo_data_out = empty ? '0 : issue_execute_pack_t'(head_bits);

endmodule

// File: tb/tb_issue_div_fifo.sv
// Directed bench for issue_div_fifo: a queue scoreboard tracks accepted pushes and
// checks head, valid, full and count every cycle before the clock edge.
module tb_issue_div_fifo;
  import issue_div_fifo_pkg::*;

  localparam int DEPTH = DIV_FIFO_DEPTH;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                rst;
  issue_execute_pack_t data_in;
  logic                push;
  logic                full;
  issue_execute_pack_t data_out;
  logic                valid;
  logic                pop;
  logic                flush;
  logic [CNT_W-1:0]    count;

  int total = 0;
  int bad   = 0;
  issue_execute_pack_t exp_q [$];

  always #5 clk = ~clk;

  issue_div_fifo #(.DEPTH(DEPTH)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .issue_div_fifo_data_in        (data_in),
    .issue_div_fifo_push           (push),
    .issue_div_fifo_full           (full),
    .issue_div_fifo_data_out       (data_out),
    .issue_div_fifo_data_out_valid (valid),
    .issue_div_fifo_pop            (pop),
    .issue_div_fifo_flush          (flush),
    .issue_div_fifo_count          (count)
  );

  function automatic issue_execute_pack_t make_pack(input int rob);
    issue_execute_pack_t p;
    logic [31:0] r;
    r          = rob;
    p.fb_en    = 1'b1;
    p.op       = div_op_t'(r[1:0]);
    p.rd_addr  = r[4:0] ^ 5'h15;
    p.rob_id   = r[ROB_ID_W-1:0];
    p.rs1_data = 32'hA500_0000 ^ (r * 32'd7919);
    p.rs2_data = 32'h0000_5A5A + r;
    return p;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Compare live outputs against the scoreboard, then apply one clock of stimulus.
  task automatic step(input logic p_push, input logic p_pop, input logic p_flush, input int rob);
    issue_execute_pack_t exp_head;
    int                  n;
    push    = p_push;
    pop     = p_pop;
    flush   = p_flush;
    data_in = make_pack(rob);
    n        = exp_q.size();
    exp_head = (n != 0) ? exp_q[0] : '0;
    check("valid", 128'(valid), 128'(n != 0));
    check("count", 128'(count), 128'(n));
    check("full",  128'(full),  128'(n == DEPTH));
    check("head",  128'(data_out), 128'(exp_head));
    if (p_flush) begin
      exp_q.delete();
    end else begin
      if (p_pop && n != 0) void'(exp_q.pop_front());
      if (p_push && n != DEPTH) exp_q.push_back(make_pack(rob));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    push    = 1'b0;
    pop     = 1'b1;
    flush   = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1. Reset state, and a pop on an empty queue does nothing.
    check("rst_valid", 128'(valid), 128'(0));
    check("rst_full",  128'(full),  128'(0));
    check("rst_count", 128'(count), 128'(0));
    check("rst_data",  128'(data_out), 128'(0));
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);

    // 2. Fill 0..15, drop a 17th push, drain in order.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, i);
    check("fill_full",  128'(full),  128'(1));
    check("fill_count", 128'(count), 128'(DEPTH));
    step(1'b1, 1'b0, 1'b0, 99);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 0);
    check("drain_valid", 128'(valid), 128'(0));

    // 3. Wrap-around: indices cross DEPTH-1 -> 0.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 20 + i);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 40 + i);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 0);
    check("wrap_count", 128'(count), 128'(0));

    // 4. Concurrent push/pop at count=5, heads 3,4,...
    for (int i = 3; i < 8; i++) step(1'b1, 1'b0, 1'b0, i);
    for (int i = 8; i < 16; i++) step(1'b1, 1'b1, 1'b0, i);
    check("conc_count", 128'(count), 128'(5));
    check("conc_head",  128'(data_out.rob_id), 128'(11));

    // 5. Full with push+pop: pop taken, push dropped.
    for (int i = 16; i < 27; i++) step(1'b1, 1'b0, 1'b0, i);
    check("full_again", 128'(full), 128'(1));
    step(1'b1, 1'b1, 1'b0, 77);
    check("fullpp_count", 128'(count), 128'(DEPTH - 1));
    step(1'b0, 1'b0, 1'b1, 0);

    // 6. Flush beats push and pop; a later push appears one cycle after it.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 60 + i);
    step(1'b1, 1'b1, 1'b1, 88);
    check("flush_count", 128'(count), 128'(0));
    check("flush_valid", 128'(valid), 128'(0));
    step(1'b1, 1'b0, 1'b0, 42);
    check("post_flush_head", 128'(data_out), 128'(make_pack(42)));
    step(1'b0, 1'b0, 1'b0, 0);

    // Mid-stream reset behaves like flush.
    step(1'b1, 1'b0, 1'b0, 5);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
